alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port round-robin arbiter that time-shares the single 32-bit combinational ALU between two requesters, e.g. the execute stage and a multicycle helper unit. It latches the winning request's operation code and operands, drives them into the ALU for one cycle, and captures ALUResult, Zero and Jr into output registers. It then returns them to the winner with a one-cycle done pulse. The block sits between the requesters and the ALU's ALUOperation/A/B inputs and ALUResult/Zero/Jr outputs.

## Interface
- WIDTH, 32, operand/result width; must match the ALU data width
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req0, req1  in  1 each  request from requester 0 / 1; held high until that requester's done pulse
- op0, op1  in  4 each  ALU operation code (ADD 0011, SUB 0111, AND 0000, OR 0001, NOR 0101, LUI 0010, SLL 0100, SRL 0110, JR 1000)
- a0, b0, a1, b1  in  WIDTH each  operands for requester 0 / 1
- alu_result  in  WIDTH  ALUResult from the ALU
- alu_zero  in  1  Zero from the ALU
- alu_jr  in  1  Jr from the ALU
- alu_op  out  4  drives ALU ALUOperation; registered
- alu_a, alu_b  out  WIDTH each  drive ALU A/B; registered
- gnt0, gnt1  out  1 each  registered grant, one-hot or zero
- busy  out  1  high in EXEC and DONE
- done0, done1  out  1 each  one-cycle completion pulse to the winner
- result  out  WIDTH  captured ALUResult; holds until the next capture
- zero, jr  out  1 each  captured Zero / Jr; hold until the next capture

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE
  - If neither req is high: stay in IDLE. alu_op/alu_a/alu_b hold their last values.
  - If exactly one req is high: grant it.
  - If both are high: grant the requester that was not last granted.
  - On grant: latch that requester's op/a/b into alu_op/alu_a/alu_b, set its gnt, set last-grant pointer, go to EXEC.
- EXEC
  - The ALU evaluates the registered operands combinationally.
  - At the end of the cycle, capture alu_result, alu_zero and alu_jr into result, zero and jr.
  - Assert done for the granted requester (registered) and go to DONE.
- DONE
  - done of the winner is high for this cycle only; gnt stays high.
  - No arbitration happens in DONE.
  - At the end of the cycle: clear done and gnt, go to IDLE.
- Last-grant pointer resets to 1, so requester 0 wins the first simultaneous contention.
- Requester handshake:
  - Operands and op must be valid in the IDLE cycle in which the grant is taken. Later changes are ignored.
  - The requester must drop req by the clock edge that ends DONE. A req still high in the following IDLE is treated as a new request.
- The block does not decode op and does not alter width. Codes are passed straight to the ALU; undefined codes yield whatever the ALU returns (0).
- Reset values:
  - 0: alu_op, alu_a, alu_b, gnt0, gnt1, busy, done0, done1, result, zero, jr
  - 1: last-grant pointer

## Timing
- Grant latency: req high in IDLE cycle n, then gnt and latched operands are visible in cycle n+1 (EXEC).
- Result latency: result/zero/jr and done are valid in cycle n+2 (DONE). The earliest next grant is taken in cycle n+3.
- Throughput: one operation per 3 cycles. Under continuous contention, grants alternate 0,1,0,1.
- A req rising during EXEC or DONE waits for IDLE and is not lost while held.
- Asynchronous reset asserted mid-EXEC or mid-DONE:
  - All outputs go to their reset values immediately and the FSM returns to IDLE.
  - No done is emitted for the aborted operation. The requester must re-request.
- gnt0 and gnt1 are never both high. done_k implies gnt_k in the same cycle.

## Test plan
- Single request, ADD: req0, op0=0011, a0=5, b0=7 in cycle 0. Expect alu_op=0011, alu_a=5, alu_b=7, gnt0=1 in cycle 1. Expect result=12, zero=0, done0=1 in cycle 2; done0=0 in cycle 3.
- Simultaneous requests after reset: req0 SUB 9-9, req1 OR 0xF0|0x0F. Expect requester 0 first: result=0, zero=1, done0 in cycle 2. Requester 1 is granted in cycle 3: result=0xFF, done1 in cycle 5.
- Round-robin fairness: both reqs held through 6 operations. Expect grant order 0,1,0,1,0,1; one done per 3 cycles; gnt never both high.
- JR passthrough: req1, op1=1000, a1=0x00400020. Expect result=0x00400020, jr=1, zero=0, done1 pulse. A following AND 0&0 gives jr=0, zero=1.
- Reset mid-operation: assert reset in the EXEC cycle of req0 ADD 1+1. Expect all outputs 0 immediately, no done0 pulse, and FSM in IDLE. A re-request after release completes with result=2.
- Operand change after grant: change a0 from 3 to 100 in the EXEC cycle of ADD 3+4. Expect result=7.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one combinational 32-bit ALU between two requesters using
// round-robin arbitration. A winning request's op/operands are latched and
// driven to the ALU for one cycle (EXEC). The ALU outputs are then captured
// and returned with a one-cycle done pulse (DONE).
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   req0/1, op0/1, a0/1, b0/1   requester inputs (req held until done)
//   alu_result/zero/jr     ALU outputs
//   alu_op/alu_a/alu_b     registered ALU inputs
//   gnt0/1, busy           grant status (gnt one-hot or zero)
//   done0/1                one-cycle completion pulse to the winner
//   result, zero, jr       captured ALU outputs, held until next capture
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       op0,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_jr,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             jr
);

    // state   | meaning
    // IDLE    | arbitrating; latch winner's op/operands on grant
    // EXEC    | ALU evaluates registered operands; capture at cycle end
    // DONE    | done pulse to winner; gnt held; no arbitration
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             jr_q, jr_d;
    logic             pick1;

    // Requester 1 wins when it is alone, or when both request and
    // requester 1 was not the last one served (last_q == 0).
    assign pick1 = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        result_d = result_q;
        zero_d   = zero_q;
        jr_d     = jr_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    alu_op_d = pick1 ? op1 : op0;
                    alu_a_d  = pick1 ? a1  : a0;
                    alu_b_d  = pick1 ? b1  : b0;
                    gnt0_d   = ~pick1;
                    gnt1_d   = pick1;
                    last_d   = pick1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                jr_d     = alu_jr;
                done0_d  = gnt0_q;
                done1_d  = gnt1_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            jr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            jr_q     <= jr_d;
        end
    end

    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = (state_q != ST_IDLE);
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign jr     = jr_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [31:0] alu_result;
    logic        alu_zero, alu_jr;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        gnt0, gnt1, busy, done0, done1;
    logic [31:0] result;
    logic        zero, jr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        z;
        logic        j;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_jr(alu_jr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done0(done0), .done1(done1),
        .result(result), .zero(zero), .jr(jr)
    );

    // Combinational ALU the arbiter is attached to.
    always_comb begin
        alu_result = '0;
        alu_jr     = 1'b0;
        case (alu_op)
            4'b0011: alu_result = alu_a + alu_b;
            4'b0111: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0101: alu_result = ~(alu_a | alu_b);
            4'b0010: alu_result = {alu_b[15:0], 16'h0000};
            4'b0100: alu_result = alu_b << alu_a[4:0];
            4'b0110: alu_result = alu_b >> alu_a[4:0];
            4'b1000: begin alu_result = alu_a; alu_jr = 1'b1; end
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // Monitor: pops the scoreboard whenever a done pulse appears.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (gnt0 && gnt1) begin
                failures++;
                $display("FAIL gnt_onehot actual gnt0=%b gnt1=%b required not both high", gnt0, gnt1);
            end
            checks++;
            if ((done0 && !gnt0) || (done1 && !gnt1)) begin
                failures++;
                $display("FAIL done_implies_gnt actual done=%b%b gnt=%b%b", done1, done0, gnt1, gnt0);
            end
            if (done0 || done1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual done0=%b done1=%b required no done", done0, done1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ((done0 && done1) || (done1 !== e.port) || (result !== e.res) ||
                        (zero !== e.z) || (jr !== e.j)) begin
                        failures++;
                        $display("FAIL sb_result actual done=%b%b result=%h zero=%b jr=%b required port=%0d result=%h zero=%b jr=%b",
                                 done1, done0, result, zero, jr, e.port, e.res, e.z, e.j);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] res, input logic z, input logic j);
        exp_t e;
        e.port = port; e.res = res; e.z = z; e.j = j;
        exp_q.push_back(e);
    endtask

    // Issue one request at a negedge in IDLE, wait (bounded) for its done, drop req.
    task automatic run_op(input logic port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z,
                          input logic j);
        int n;
        push(port, res, z, j);
        if (port) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else      begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? done1 : done0) && n < 10);
        chk("run_op_latency", n, 2);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int gap;
        reset = 1'b1;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {alu_op, gnt0, gnt1, busy, done0, done1, zero, jr}, 32'd0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single ADD 5+7
        push(1'b0, 32'd12, 1'b0, 1'b0);
        req0 = 1; op0 = 4'b0011; a0 = 5; b0 = 7;
        @(negedge clk);
        chk("add_alu_op", alu_op, 4'b0011);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 7);
        chk("add_gnt0_busy", {gnt0, gnt1, busy}, 3'b101);
        @(negedge clk);
        chk("add_done0", {done0, done1}, 2'b10);
        chk("add_result", result, 12);
        req0 = 0;
        @(negedge clk);
        chk("add_done0_clear", {done0, gnt0, busy}, 3'b000);

        // Simultaneous after reset: requester 0 first
        do_reset();
        push(1'b0, 32'd0, 1'b1, 1'b0);
        push(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        req0 = 1; op0 = 4'b0111; a0 = 9; b0 = 9;
        req1 = 1; op1 = 4'b0001; a1 = 32'hF0; b1 = 32'h0F;
        @(negedge clk);
        chk("sim_c1_gnt", {gnt0, gnt1}, 2'b10);
        @(negedge clk);
        chk("sim_c2_done0", {done0, zero}, 2'b11);
        req0 = 0;
        @(negedge clk);
        chk("sim_c3_idle", busy, 0);
        @(negedge clk);
        chk("sim_c4_gnt1", {gnt0, gnt1}, 2'b01);
        @(negedge clk);
        chk("sim_c5_done1", {done1, result}, {1'b1, 32'hFF});
        req1 = 0;
        @(negedge clk);

        // Fairness: both held; last served was 1, so 0 goes first
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(1'b0, 32'd3, 1'b0, 1'b0);
            else            push(1'b1, 32'd6, 1'b0, 1'b0);
        end
        req0 = 1; op0 = 4'b0011; a0 = 1;  b0 = 2;
        req1 = 1; op1 = 4'b0111; a1 = 10; b1 = 4;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(done0 || done1) && n < 10);
            chk("rr_gap", n, (k == 0) ? 2 : 3);
            chk("rr_order", {done0, done1}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // JR passthrough
        run_op(1'b1, 4'b1000, 32'h0040_0020, 32'd0, 32'h0040_0020, 1'b0, 1'b1);

        // Reset during EXEC of ADD 1+1
        req0 = 1; op0 = 4'b0011; a0 = 1; b0 = 1;
        @(negedge clk);
        chk("rst_mid_gnt0", {gnt0, busy}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_flags", {alu_op, gnt0, gnt1, busy, done0, done1, zero, jr}, 32'd0);
        chk("rst_mid_alu_a", alu_a, 0);
        chk("rst_mid_result", result, 0);
        req0 = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", {done0, busy}, 2'b00);
        run_op(1'b0, 4'b0011, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

        // AND 0&0 after a JR: jr clears, zero sets
        run_op(1'b1, 4'b1000, 32'h0000_0044, 32'd0, 32'h0000_0044, 1'b0, 1'b1);
        run_op(1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Operand change after grant is ignored
        push(1'b0, 32'd7, 1'b0, 1'b0);
        req0 = 1; op0 = 4'b0011; a0 = 3; b0 = 4;
        @(negedge clk);
        a0 = 100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 10);
        chk("opchg_latency", n, 1);
        chk("opchg_result", result, 7);
        req0 = 0;
        repeat (3) @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
